ws2812_frame_ctrl: RTL and testbench

- Sequences one 8x8 RGB LED-matrix frame onto a single WS2812-style serial data line.
- Drives the picture-select input of the picture ROM, captures the selected 64x24-bit flattened frame into an internal shift buffer, and serialises it pixel by pixel, MSB first, with NRZ high/low pulse timing.
- Ends every frame with a latch/reset gap.
- Queues at most one request that arrives while a frame is in progress.

---
 rtl/ws2812_frame_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ws2812_frame_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame sequencer: latches one picture from the ROM and serialises it
// MSB first with NRZ pulse timing, then holds the line low for the latch gap.
module ws2812_frame_ctrl #(
  parameter int unsigned LED_NUM = 64,
  parameter int unsigned T0H_CYC = 20,
  parameter int unsigned T1H_CYC = 40,
  parameter int unsigned BIT_CYC = 63,
  parameter int unsigned RST_CYC = 15000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   start,
  input  logic [1:0]             pic_sel,
  output logic [1:0]             pic_num,
  input  logic [24*LED_NUM-1:0]  pic_flattened,
  output logic                   dout,
  output logic [5:0]             cnt_led,
  output logic [4:0]             cnt_bit,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned FrameW = 24 * LED_NUM;
  // The counter also times the latch gap plus its trailing done cycle.
  localparam int unsigned CycMax = (RST_CYC + 1 > BIT_CYC) ? RST_CYC + 1 : BIT_CYC;
  localparam int unsigned CycW   = $clog2(CycMax + 1);

  localparam logic [CycW-1:0] BitLast = CycW'(BIT_CYC - 1);
  localparam logic [CycW-1:0] GapLast = CycW'(RST_CYC);
  localparam logic [CycW-1:0] GapDone = CycW'(RST_CYC + 1);
  localparam logic [CycW-1:0] T0h     = CycW'(T0H_CYC);
  localparam logic [CycW-1:0] T1h     = CycW'(T1H_CYC);
  localparam logic [5:0]      LedLast = 6'(LED_NUM - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StRstGap} state_e;

  state_e              state_q, state_d;
  logic [CycW-1:0]     cyc_q, cyc_d;
  logic [5:0]          cnt_led_q, cnt_led_d;
  logic [4:0]          cnt_bit_q, cnt_bit_d;
  logic [FrameW-1:0]   buf_q, buf_d;
  logic [1:0]          pic_num_q, pic_num_d;
  logic                pend_q, pend_d;
  logic [1:0]          pend_sel_q, pend_sel_d;
  logic                dout_q, dout_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [23:0]         cur_pix;
  logic [4:0]          bit_idx;
  logic                cur_bit;

  // The buffer shifts one pixel per pixel boundary, so the live pixel is always at the bottom.
  assign cur_pix = buf_q[23:0];
  assign bit_idx = 5'd23 - cnt_bit_q;
  assign cur_bit = cur_pix[bit_idx];

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    cnt_led_d  = cnt_led_q;
    cnt_bit_d  = cnt_bit_q;
    buf_d      = buf_q;
    pic_num_d  = pic_num_q;
    pend_d     = pend_q;
    pend_sel_d = pend_sel_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dout_d     = 1'b0;

    if (state_q != StIdle && start) begin
      pend_d     = 1'b1;
      pend_sel_d = pic_sel;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pic_num_d = pic_sel;
          busy_d    = 1'b1;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        buf_d     = pic_flattened;
        cnt_led_d = '0;
        cnt_bit_d = '0;
        cyc_d     = '0;
        state_d   = StSend;
      end
      StSend: begin
        dout_d = (cyc_q < (cur_bit ? T1h : T0h));
        if (cyc_q == BitLast) begin
          cyc_d = '0;
          if (cnt_bit_q == 5'd23) begin
            if (cnt_led_q == LedLast) begin
              dout_d  = 1'b0;
              state_d = StRstGap;
            end else begin
              cnt_bit_d = '0;
              cnt_led_d = cnt_led_q + 6'd1;
              buf_d     = buf_q >> 24;
            end
          end else begin
            cnt_bit_d = cnt_bit_q + 5'd1;
          end
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StRstGap: begin
        if (cyc_q == GapDone) begin
          cyc_d = '0;
          // pend_d already folds in a start arriving on this very cycle.
          if (pend_d) begin
            pic_num_d = pend_sel_d;
            pend_d    = 1'b0;
            busy_d    = 1'b1;
            state_d   = StLoad;
          end else begin
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end else begin
          cyc_d = cyc_q + CycW'(1);
          if (cyc_q == GapLast) begin
            done_d = 1'b1;
            busy_d = pend_d;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      cyc_q      <= '0;
      cnt_led_q  <= '0;
      cnt_bit_q  <= '0;
      buf_q      <= '0;
      pic_num_q  <= '0;
      pend_q     <= 1'b0;
      pend_sel_q <= '0;
      dout_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      cnt_led_q  <= cnt_led_d;
      cnt_bit_q  <= cnt_bit_d;
      buf_q      <= buf_d;
      pic_num_q  <= pic_num_d;
      pend_q     <= pend_d;
      pend_sel_q <= pend_sel_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign pic_num = pic_num_q;
  assign dout    = dout_q;
  assign cnt_led = cnt_led_q;
  assign cnt_bit = cnt_bit_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Bench for ws2812_frame_ctrl: a frame-timeline model checked every cycle,
// plus literal expectations for latency, pulse shapes, queuing and reset.
module tb_ws2812_frame_ctrl;

  localparam int LED    = 64;
  localparam int T0H    = 2;
  localparam int T1H    = 4;
  localparam int BITC   = 6;
  localparam int RSTC   = 10;
  localparam int FW     = 24 * LED;
  localparam int F      = FW * BITC;     // SEND cycles per frame
  localparam int DONE_R = F + RSTC + 2;  // edges after LOAD entry at which done shows
  localparam int LAST_B = FW - 1;

  logic          sys_clk, sys_rst, start;
  logic [1:0]    pic_sel, pic_num;
  logic [FW-1:0] pic_flattened;
  logic          dout, busy, done;
  logic [5:0]    cnt_led;
  logic [4:0]    cnt_bit;

  logic [FW-1:0] rom [4];
  logic          corrupt;

  int errors = 0;
  int checks = 0;
  int idx;

  ws2812_frame_ctrl #(
    .LED_NUM(LED), .T0H_CYC(T0H), .T1H_CYC(T1H), .BIT_CYC(BITC), .RST_CYC(RSTC)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .pic_sel(pic_sel),
    .pic_num(pic_num), .pic_flattened(pic_flattened), .dout(dout),
    .cnt_led(cnt_led), .cnt_bit(cnt_bit), .busy(busy), .done(done)
  );

  assign pic_flattened = corrupt ? ~rom[pic_num] : rom[pic_num];

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Timeline model: each frame is addressed by edges since LOAD entry (m_rel).
  bit            m_active, m_pend;
  int            m_rel, m_hold;
  logic [FW-1:0] m_frame;
  logic [1:0]    m_pic, m_pend_sel;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_active <= 0; m_pend <= 0; m_rel <= 0; m_hold <= 0;
      m_frame <= '0; m_pic <= 2'd0; m_pend_sel <= 2'd0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1; m_rel <= 0; m_pic <= pic_sel;
      end
    end else begin
      if (start) begin
        m_pend <= 1; m_pend_sel <= pic_sel;
      end
      if (m_rel == 0) m_frame <= pic_flattened;
      if (m_rel == DONE_R) begin
        m_hold <= LAST_B;
        if (m_pend || start) begin
          m_rel  <= 0;
          m_pic  <= start ? pic_sel : m_pend_sel;
          m_pend <= 0;
        end else begin
          m_active <= 0;
        end
      end else begin
        m_rel <= m_rel + 1;
      end
    end
  end

  function automatic bit exp_dout();
    int k, b, v;
    if (!m_active || m_rel < 2 || m_rel > F + 1) return 1'b0;
    k = m_rel - 2;
    b = k / BITC;
    v = int'(m_frame[(b / 24) * 24 + 23 - (b % 24)]);
    return (k % BITC) < (v != 0 ? T1H : T0H);
  endfunction

  function automatic int exp_b();
    int b;
    if (!m_active || m_rel < 1) return m_hold;
    b = (m_rel - 1) / BITC;
    return (b > LAST_B) ? LAST_B : b;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      cmp("dout", 32'(dout), 32'(exp_dout()));
      cmp("busy", 32'(busy), 32'(m_active && (m_rel != DONE_R || m_pend)));
      cmp("done", 32'(done), 32'(m_active && m_rel == DONE_R));
      cmp("pic_num", 32'(pic_num), 32'(m_pic));
      cmp("cnt_led", 32'(cnt_led), 32'(exp_b() / 24));
      cmp("cnt_bit", 32'(cnt_bit), 32'(exp_b() % 24));
    end
  end

  task automatic adv(input int target);
    while (idx < target) begin
      @(negedge sys_clk);
      idx++;
    end
  endtask

  task automatic pulse(input logic [1:0] sel);
    start = 1'b1; pic_sel = sel;
    @(negedge sys_clk);
    idx++;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      @(negedge sys_clk);
      idx++; n++;
    end
    cmp("done_seen", 32'(done), 32'd1);
  endtask

  bit first12 [12] = '{1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
  bit one6    [6]  = '{1, 1, 1, 1, 0, 0};

  initial begin
    int seen;
    for (int i = 0; i < LED; i++) begin
      rom[0][24*i +: 24] = {8'(i), 8'(i * 3), 8'(255 - i)};
      rom[1][24*i +: 24] = (i == 0) ? 24'h00FF00 : 24'h000000;
      rom[2][24*i +: 24] = 24'hA5C30F ^ {8'(i), 8'(i), 8'(i)};
      rom[3][24*i +: 24] = 24'hFFFFFF;
    end
    sys_rst = 1'b1; start = 1'b0; pic_sel = 2'd0; corrupt = 1'b0; idx = 0;
    repeat (3) @(negedge sys_clk);
    cmp("rst_dout", 32'(dout), 0);
    cmp("rst_busy", 32'(busy), 0);
    cmp("rst_done", 32'(done), 0);
    cmp("rst_pic_num", 32'(pic_num), 0);
    cmp("rst_cnt_led", 32'(cnt_led), 0);
    cmp("rst_cnt_bit", 32'(cnt_bit), 0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Frame A, picture 1: latency, pulse shapes, pixel boundary.
    pulse(2'd1);
    cmp("a_pic_num", 32'(pic_num), 1);
    cmp("a_busy", 32'(busy), 1);
    cmp("a_dout_load", 32'(dout), 0);
    idx = -2;
    adv(-1);
    cmp("a_dout_e1", 32'(dout), 0);
    for (int i = 0; i < 12; i++) begin
      adv(i);
      cmp("a_zero_pulse", 32'(dout), 32'(first12[i]));
    end
    for (int i = 0; i < 6; i++) begin
      adv(48 + i);
      cmp("a_one_pulse", 32'(dout), 32'(one6[i]));
    end
    adv(97);
    cmp("a_bit16_hi", 32'(dout), 1);
    adv(98);
    cmp("a_bit16_lo", 32'(dout), 0);
    adv(100);
    cmp("a_cnt_led0", 32'(cnt_led), 0);
    cmp("a_cnt_bit16", 32'(cnt_bit), 16);
    adv(146);
    cmp("a_cnt_led1", 32'(cnt_led), 1);
    cmp("a_cnt_bit0", 32'(cnt_bit), 0);

    // ROM output changes mid-frame; two queued requests, newest wins.
    adv(200);
    corrupt = 1'b1;
    adv(300);
    pulse(2'd2);
    adv(500);
    pulse(2'd0);
    adv(600);
    corrupt = 1'b0;
    cmp("a_pic_num_hold", 32'(pic_num), 1);
    wait_done(9000);
    cmp("a_frame_len", 32'(idx), 32'(DONE_R - 2));
    cmp("a_busy_at_done", 32'(busy), 1);
    @(negedge sys_clk);
    cmp("b_pic_num", 32'(pic_num), 0);
    cmp("b_busy", 32'(busy), 1);
    cmp("b_done_gone", 32'(done), 0);
    idx = -2;

    // Frame B, picture 0: start lands on the done cycle.
    wait_done(9300);
    cmp("b_frame_len", 32'(idx), 32'(DONE_R - 2));
    cmp("b_busy_at_done", 32'(busy), 0);
    pulse(2'd3);
    cmp("c_pic_num", 32'(pic_num), 3);
    cmp("c_busy", 32'(busy), 1);
    cmp("c_done_gone", 32'(done), 0);

    // Frame C, picture 3: reset mid-frame at pixel 10 bit 5.
    seen = 0;
    while (!(cnt_led == 6'd10 && cnt_bit == 5'd5) && seen < 3000) begin
      @(negedge sys_clk);
      seen++;
    end
    cmp("c_reached_px10", 32'(cnt_led), 10);
    #2 sys_rst = 1'b1;
    #1;
    cmp("mr_dout", 32'(dout), 0);
    cmp("mr_busy", 32'(busy), 0);
    cmp("mr_cnt_led", 32'(cnt_led), 0);
    cmp("mr_cnt_bit", 32'(cnt_bit), 0);
    cmp("mr_pic_num", 32'(pic_num), 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      if (done === 1'b1) seen++;
    end
    cmp("mr_no_done", 32'(seen), 0);
    cmp("mr_idle_busy", 32'(busy), 0);

    // Frame D, picture 2: full frame after a fresh start.
    pulse(2'd2);
    cmp("d_pic_num", 32'(pic_num), 2);
    idx = -2;
    wait_done(9300);
    cmp("d_frame_len", 32'(idx), 32'(DONE_R - 2));
    repeat (5) @(negedge sys_clk);
    cmp("d_idle_busy", 32'(busy), 0);
    cmp("d_hold_cnt_led", 32'(cnt_led), 63);
    cmp("d_hold_cnt_bit", 32'(cnt_bit), 23);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
